// File: rtl/muller_pipe_tx_bridge_if.sv
// Stream-in / 4-phase-out signal bundle for the Muller pipeline transmit bridge.
// master = bridge side, slave = upstream producer plus async Muller stage.
interface muller_pipe_tx_bridge_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]         in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         data_out;
   logic                     req;
   logic                     ack;
   logic [$clog2(DEPTH):0]   count;
   logic                     busy;

   modport master (
      input  in_data, in_valid, ack,
      output in_ready, data_out, req, count, busy
   );

   modport slave (
      output in_data, in_valid, ack,
      input  in_ready, data_out, req, count, busy
   );
endinterface

// File: rtl/muller_pipe_tx_bridge.sv
// Buffers a valid/ready word stream in a small FIFO and launches each word into a
// Muller C-element pipeline with a return-to-zero req/ack handshake.
module muller_pipe_tx_bridge #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   muller_pipe_tx_bridge_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [WIDTH-1:0]   data_out_reg;
   logic               req_reg, req_next;
   logic               ack_sync_reg [SYNC_STAGES];
   logic               ack_s;
   logic               in_ready;
   logic               push;
   logic               pop;

   // ack comes from an asynchronous C-element: only the last synchronizer flop is trusted
   always_ff @(posedge clk) begin
      if (rst) ack_sync_reg[0] <= 1'b0;
      else     ack_sync_reg[0] <= bus.ack;
   end

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_ack_sync
         always_ff @(posedge clk) begin
            if (rst) ack_sync_reg[gi] <= 1'b0;
            else     ack_sync_reg[gi] <= ack_sync_reg[gi-1];
         end
      end
   endgenerate

   assign ack_s    = ack_sync_reg[SYNC_STAGES-1];
   assign in_ready = !rst && (count_reg < CNT_W'(DEPTH));
   assign push     = bus.in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= bus.in_data;
   end

   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               pop        = 1'b1;
               state_next = SETUP;
            end
         end
         // one idle cycle lets data_out settle before req can fire the C-element
         SETUP: begin
            req_next   = 1'b1;
            state_next = REQ_HI;
         end
         REQ_HI: begin
            if (ack_s) begin
               req_next   = 1'b0;
               state_next = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         req_reg      <= 1'b0;
         data_out_reg <= '0;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         req_reg   <= req_next;
         count_reg <= count_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop) begin
            data_out_reg <= mem[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.data_out = data_out_reg;
   assign bus.req      = req_reg;
   assign bus.count    = count_reg;
   assign bus.busy     = (count_reg != '0) || (state_reg != IDLE);
endmodule

// File: tb/tb_muller_pipe_tx_bridge.sv
// Scoreboard bench: pushed words are queued in order; a monitor pops and compares
// on every req rising edge, with a delayed-ack model standing in for the Muller stage.
module tb_muller_pipe_tx_bridge;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stall_ack = 1'b0;
   logic ack_drv = 1'b0;
   logic ack_glitch = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [WIDTH-1:0] exp_q [$];

   muller_pipe_tx_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   muller_pipe_tx_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.ack = ack_drv | ack_glitch;

   // Muller stage model: ack follows req after 3 ns unless the stage is stalled
   initial begin
      forever begin
         @(bus.req or stall_ack);
         #3;
         ack_drv = bus.req && !stall_ack;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: every new req launches the oldest outstanding word
   initial begin
      logic             prev_req;
      logic [WIDTH-1:0] held;
      logic [WIDTH-1:0] want;
      prev_req = 1'b0;
      held     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.req === 1'b1 && !prev_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 32'(bus.data_out), 32'hFFFF_FFFF);
            end else begin
               want = exp_q.pop_front();
               check("word_order", 32'(bus.data_out), 32'(want));
               $display("word 0x%02h delivered", bus.data_out);
            end
            held = bus.data_out;
         end else if (bus.req === 1'b1) begin
            check("data_stable_req_hi", 32'(bus.data_out), 32'(held));
         end
         prev_req = (bus.req === 1'b1);
      end
   end

   // call at a falling edge; returns at the next falling edge
   task automatic push_word(input logic [WIDTH-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (bus.in_ready === 1'b1) exp_q.push_back(d);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, 32'(exp_q.size()), 0);
      check({name, "_busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // 1: reset and idle
      repeat (3) @(negedge clk);
      check("in_ready_in_reset", 32'(bus.in_ready), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_req", 32'(bus.req), 0);
      check("idle_data_out", 32'(bus.data_out), 0);
      check("idle_count", 32'(bus.count), 0);
      check("idle_in_ready", 32'(bus.in_ready), 1);
      check("idle_busy", 32'(bus.busy), 0);

      // 2: single word latency and handshake timing
      push_word(8'hA5);
      check("lat_count_t", 32'(bus.count), 1);
      check("lat_req_t", 32'(bus.req), 0);
      @(negedge clk);
      check("lat_data_t1", 32'(bus.data_out), 32'hA5);
      check("lat_req_t1", 32'(bus.req), 0);
      @(negedge clk);
      check("lat_req_t2", 32'(bus.req), 1);
      n = 0;
      while (bus.req === 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("req_fall_edges_in_window", 32'(n >= SYNC && n <= SYNC + 1), 1);
      drain("single");

      // 3: stalled stage fills the FIFO
      stall_ack = 1'b1;
      for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
      check("stall_count_full", 32'(bus.count), DEPTH);
      check("stall_in_ready", 32'(bus.in_ready), 0);
      check("stall_req", 32'(bus.req), 1);
      check("stall_head", 32'(bus.data_out), 32'h01);
      push_word(8'h06);
      check("full_no_overwrite", 32'(bus.count), DEPTH);
      stall_ack = 1'b0;
      drain("stall");

      // 4: random stream with full-rate drain
      for (int i = 0; i < 120; i++) begin
         check("in_ready_vs_count", 32'(bus.in_ready), 32'(bus.count < DEPTH));
         if ($urandom_range(0, 3) != 0) push_word(WIDTH'($urandom));
         else @(negedge clk);
      end
      drain("random");

      // 5: reset mid-handshake
      stall_ack = 1'b1;
      for (int i = 0; i < 4; i++) push_word(8'h10 + WIDTH'(i));
      check("pre_rst_req", 32'(bus.req), 1);
      check("pre_rst_count", 32'(bus.count), 3);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rst_req", 32'(bus.req), 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_data_out", 32'(bus.data_out), 0);
      stall_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
      push_word(8'h3C);
      drain("post_rst");

      // 6: ack glitches in IDLE and SETUP are ignored
      #2 ack_glitch = 1'b1;
      #1 ack_glitch = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("glitch_idle_busy", 32'(bus.busy), 0);
      check("glitch_idle_req", 32'(bus.req), 0);
      push_word(8'h5A);
      @(negedge clk);
      #2 ack_glitch = 1'b1;
      #1 ack_glitch = 1'b0;
      @(negedge clk);
      check("glitch_setup_req", 32'(bus.req), 1);
      drain("glitch");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
